// File: rtl/calculator_ctrl.sv
// calculator_ctrl: BCD calculator front-end FSM; optional ALU wait timeout via CALC_CTRL_TIMEOUT_EN
module calculator_ctrl #(
    parameter int unsigned TIMEOUT_CYCLES = 1024
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        button_clr,
    input  logic        button_ent,
    input  logic        slider_1,
    input  logic        slider_2,
    input  logic        slider_3,
    input  logic        slider_4,
    input  logic        slider_arith,
    input  logic        alu_done,
    input  logic [15:0] alu_result,
    input  logic        alu_neg,
    input  logic        alu_ovf,
    output logic [15:0] operand_a,
    output logic [15:0] operand_b,
    output logic        op_sub,
    output logic        alu_start,
    output logic [15:0] disp_bcd,
    output logic        disp_neg,
    output logic        disp_err,
    output logic [2:0]  state_o
);
    localparam logic [2:0] ENTER_A = 3'd0;
    localparam logic [2:0] ENTER_B = 3'd1;
    localparam logic [2:0] START   = 3'd2;
    localparam logic [2:0] WAIT    = 3'd3;
    localparam logic [2:0] RESULT  = 3'd4;
    localparam logic [2:0] ERROR   = 3'd5;
    logic [2:0]  state_q, state_d;
    logic [15:0] operand_a_q, operand_a_d, operand_b_q, operand_b_d, res_q, res_d;
    logic        op_sub_q, op_sub_d, neg_q, neg_d;
    logic [5:0]  prev_q, prev_d, btn, rise;
    logic        tmo;
    assign btn  = {slider_4, slider_3, slider_2, slider_1, button_ent, button_clr};
    assign rise = btn & ~prev_q;
    // a timeout shorter than two cycles cannot be expressed by the WAIT counter
    if (TIMEOUT_CYCLES < 2) begin : g_timeout_cycles_too_small
    end
`ifdef CALC_CTRL_TIMEOUT_EN
    localparam int CW = $clog2(TIMEOUT_CYCLES);
    logic [CW-1:0] cnt_q, cnt_d;
    assign tmo = cnt_q == CW'(TIMEOUT_CYCLES - 1);
    // counter restarts from zero on every WAIT entry and runs only while waiting
    always_comb cnt_d = (state_q == WAIT) ? cnt_q + CW'(1) : '0;
    // timeout counter register
    always_ff @(posedge clk)
        cnt_q <= reset ? '0 : cnt_d;
`else
    assign tmo = 1'b0;
`endif
    function automatic logic [15:0] bump(input logic [15:0] v, input logic [3:0] e);
        logic [15:0] r;
        r = v;
        for (int i = 0; i < 4; i++)
            if (e[i]) r[4*i +: 4] = (v[4*i +: 4] >= 4'd9) ? 4'd0 : v[4*i +: 4] + 4'd1;
        return r;
    endfunction
    // next-state and datapath: clear edge overrides everything else
    always_comb begin
        prev_d      = btn;
        state_d     = state_q;
        operand_a_d = operand_a_q;
        operand_b_d = operand_b_q;
        op_sub_d    = op_sub_q;
        res_d       = res_q;
        neg_d       = neg_q;
        if (rise[0]) begin
            state_d     = ENTER_A;
            operand_a_d = '0;
            operand_b_d = '0;
            op_sub_d    = 1'b0;
            res_d       = '0;
            neg_d       = 1'b0;
        end else begin
            case (state_q)
                ENTER_A: begin
                    operand_a_d = bump(operand_a_q, rise[5:2]);
                    if (rise[1]) begin
                        operand_b_d = '0;
                        state_d     = ENTER_B;
                    end
                end
                ENTER_B: begin
                    operand_b_d = bump(operand_b_q, rise[5:2]);
                    if (rise[1]) begin
                        op_sub_d = slider_arith;
                        state_d  = START;
                    end
                end
                START: state_d = WAIT;
                WAIT: begin
                    if (alu_done) begin
                        res_d   = alu_result;
                        neg_d   = alu_neg;
                        state_d = alu_ovf ? ERROR : RESULT;
                    end else if (tmo) begin
                        state_d = ERROR;
                    end
                end
                RESULT: begin
                    if (rise[1]) begin
                        operand_a_d = neg_q ? '0 : res_q;
                        operand_b_d = neg_q ? operand_b_q : '0;
                        state_d     = neg_q ? ENTER_A : ENTER_B;
                    end
                end
                ERROR: state_d = ERROR;
                default: state_d = ENTER_A;
            endcase
        end
    end
    // state registers; edge detectors track input levels even during reset
    always_ff @(posedge clk) begin
        prev_q <= prev_d;
        if (reset) begin
            state_q     <= ENTER_A;
            operand_a_q <= '0;
            operand_b_q <= '0;
            op_sub_q    <= 1'b0;
            res_q       <= '0;
            neg_q       <= 1'b0;
        end else begin
            state_q     <= state_d;
            operand_a_q <= operand_a_d;
            operand_b_q <= operand_b_d;
            op_sub_q    <= op_sub_d;
            res_q       <= res_d;
            neg_q       <= neg_d;
        end
    end
    assign operand_a = operand_a_q;
    assign operand_b = operand_b_q;
    assign op_sub    = op_sub_q;
    assign alu_start = state_q == START;
    assign state_o   = state_q;
    assign disp_neg  = (state_q == RESULT) && neg_q;
    assign disp_err  = state_q == ERROR;
    assign disp_bcd  = (state_q == ENTER_A) ? operand_a_q :
                       (state_q == ENTER_B || state_q == START || state_q == WAIT) ? operand_b_q :
                       (state_q == RESULT) ? res_q : '0;
endmodule

// File: tb/tb_calculator_ctrl.sv
// tb_calculator_ctrl: scoreboard bench for calculator_ctrl (TIMEOUT_CYCLES=16)
module tb_calculator_ctrl;
    logic        clk, reset, button_clr, button_ent;
    logic        slider_1, slider_2, slider_3, slider_4, slider_arith;
    logic        alu_done, alu_neg, alu_ovf;
    logic [15:0] alu_result, operand_a, operand_b, disp_bcd;
    logic        op_sub, alu_start, disp_neg, disp_err;
    logic [2:0]  state_o;
    typedef struct packed {logic [15:0] a; logic [15:0] b; logic sub;} start_t;
    start_t exp_q[$];
    start_t last;
    int checks, fails;

    calculator_ctrl #(.TIMEOUT_CYCLES(16)) dut (
        .clk(clk), .reset(reset), .button_clr(button_clr), .button_ent(button_ent),
        .slider_1(slider_1), .slider_2(slider_2), .slider_3(slider_3), .slider_4(slider_4),
        .slider_arith(slider_arith), .alu_done(alu_done), .alu_result(alu_result),
        .alu_neg(alu_neg), .alu_ovf(alu_ovf), .operand_a(operand_a), .operand_b(operand_b),
        .op_sub(op_sub), .alu_start(alu_start), .disp_bcd(disp_bcd), .disp_neg(disp_neg),
        .disp_err(disp_err), .state_o(state_o)
    );

    initial begin
        clk = 0;
        forever #5 clk = ~clk;
    end

    // scoreboard: every alu_start pops one expected operand set; WAIT must hold them stable
    always @(negedge clk) begin
        if (alu_start) begin
            checks++;
            if (exp_q.size() == 0) begin
                fails++;
                $display("FAIL unexpected_start: alu_start=1 required 0");
            end else begin
                last = exp_q.pop_front();
                if ({operand_a, operand_b, op_sub} !== last) begin
                    fails++;
                    $display("FAIL start_operands: got %h/%h/%b required %h/%h/%b",
                             operand_a, operand_b, op_sub, last.a, last.b, last.sub);
                end
            end
        end
        if (state_o == 3'd3) begin
            checks++;
            if ({operand_a, operand_b, op_sub} !== last) begin
                fails++;
                $display("FAIL wait_stable: got %h/%h/%b required %h/%h/%b",
                         operand_a, operand_b, op_sub, last.a, last.b, last.sub);
            end
        end
    end

    task automatic tick(input int n = 1);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic drive(input int k, input logic v);
        case (k)
            0: button_clr = v;
            1: button_ent = v;
            2: slider_1 = v;
            3: slider_2 = v;
            4: slider_3 = v;
            default: slider_4 = v;
        endcase
    endtask

    task automatic press(input int k);
        drive(k, 1'b1);
        tick();
        drive(k, 1'b0);
        tick();
    endtask

    task automatic slide(input int k, input int n);
        repeat (n) press(k + 1);
    endtask

    task automatic alu(input logic [15:0] r, input logic n, input logic o);
        alu_result = r;
        alu_neg = n;
        alu_ovf = o;
        alu_done = 1;
        tick();
        alu_done = 0;
        tick();
    endtask

    task automatic do_reset;
        reset = 1;
        tick(2);
        reset = 0;
        tick();
    endtask

    task automatic test_reset;
        reset = 1;
        tick(2);
        checks++;
        if (state_o !== 3'd0) begin fails++; $display("FAIL reset_state: got %0d required 0", state_o); end
        checks++;
        if ({operand_a, operand_b, op_sub} !== 33'd0) begin
            fails++; $display("FAIL reset_operands: got %h/%h/%b required 0", operand_a, operand_b, op_sub);
        end
        checks++;
        if ({alu_start, disp_bcd, disp_neg, disp_err} !== 19'd0) begin
            fails++; $display("FAIL reset_outputs: got %b/%h/%b/%b required 0", alu_start, disp_bcd, disp_neg, disp_err);
        end
        reset = 0;
        tick();
    endtask

    task automatic test_digits;
        slide(1, 3);
        slide(2, 12);
        checks++;
        if (operand_a !== 16'h0023) begin fails++; $display("FAIL digits_a: got %h required 0023", operand_a); end
        checks++;
        if (disp_bcd !== 16'h0023) begin fails++; $display("FAIL digits_disp: got %h required 0023", disp_bcd); end
        slider_3 = 1;
        slider_4 = 1;
        tick();
        slider_3 = 0;
        slider_4 = 0;
        tick();
        checks++;
        if (operand_a !== 16'h1123) begin fails++; $display("FAIL digits_simul: got %h required 1123", operand_a); end
    endtask

    task automatic test_sub_negative;
        do_reset();
        slide(2, 1);
        slide(1, 2);
        press(1);
        checks++;
        if ({state_o, operand_b, disp_bcd} !== {3'd1, 16'h0, 16'h0}) begin
            fails++; $display("FAIL enter_b: got %0d/%h/%h required 1/0000/0000", state_o, operand_b, disp_bcd);
        end
        slide(1, 5);
        slider_arith = 1;
        exp_q.push_back({16'h0012, 16'h0005, 1'b1});
        press(1);
        slider_arith = 0;
        checks++;
        if (state_o !== 3'd3) begin fails++; $display("FAIL sub_wait: got %0d required 3", state_o); end
        alu(16'h0007, 1, 0);
        checks++;
        if ({state_o, disp_bcd, disp_neg} !== {3'd4, 16'h0007, 1'b1}) begin
            fails++; $display("FAIL sub_result: got %0d/%h/%b required 4/0007/1", state_o, disp_bcd, disp_neg);
        end
        press(1);
        checks++;
        if ({state_o, operand_a, disp_neg} !== {3'd0, 16'h0, 1'b0}) begin
            fails++; $display("FAIL neg_restart: got %0d/%h/%b required 0/0000/0", state_o, operand_a, disp_neg);
        end
    endtask

    task automatic test_chain_error;
        do_reset();
        slide(1, 2);
        press(1);
        slide(2, 4);
        exp_q.push_back({16'h0002, 16'h0040, 1'b0});
        press(1);
        alu(16'h0042, 0, 0);
        checks++;
        if ({state_o, disp_bcd, disp_neg} !== {3'd4, 16'h0042, 1'b0}) begin
            fails++; $display("FAIL add_result: got %0d/%h/%b required 4/0042/0", state_o, disp_bcd, disp_neg);
        end
        press(1);
        checks++;
        if ({state_o, operand_a, operand_b} !== {3'd1, 16'h0042, 16'h0}) begin
            fails++; $display("FAIL chain: got %0d/%h/%h required 1/0042/0000", state_o, operand_a, operand_b);
        end
        exp_q.push_back({16'h0042, 16'h0000, 1'b0});
        press(1);
        alu(16'h0099, 0, 1);
        checks++;
        if ({state_o, disp_err, disp_bcd, disp_neg} !== {3'd5, 1'b1, 16'h0, 1'b0}) begin
            fails++; $display("FAIL ovf_error: got %0d/%b/%h/%b required 5/1/0000/0", state_o, disp_err, disp_bcd, disp_neg);
        end
        press(1);
        slide(1, 1);
        checks++;
        if ({state_o, operand_b} !== {3'd5, 16'h0}) begin
            fails++; $display("FAIL error_sticky: got %0d/%h required 5/0000", state_o, operand_b);
        end
        press(0);
        checks++;
        if ({state_o, operand_a, disp_err} !== {3'd0, 16'h0, 1'b0}) begin
            fails++; $display("FAIL error_clr: got %0d/%h/%b required 0/0000/0", state_o, operand_a, disp_err);
        end
        alu(16'h0001, 0, 0);
        checks++;
        if ({state_o, disp_bcd} !== {3'd0, 16'h0}) begin
            fails++; $display("FAIL stray_done: got %0d/%h required 0/0000", state_o, disp_bcd);
        end
    endtask

    task automatic test_clr_priority;
        do_reset();
        slide(1, 3);
        press(1);
        slide(1, 2);
        button_clr = 1;
        button_ent = 1;
        tick();
        button_clr = 0;
        button_ent = 0;
        tick(2);
        checks++;
        if ({state_o, operand_a, operand_b, op_sub} !== {3'd0, 33'd0}) begin
            fails++; $display("FAIL clr_ent: got %0d/%h/%h/%b required 0/0/0/0", state_o, operand_a, operand_b, op_sub);
        end
        press(1);
        exp_q.push_back({16'h0, 16'h0, 1'b0});
        press(1);
        button_clr = 1;
        alu_result = 16'h0005;
        alu_neg = 1;
        alu_ovf = 0;
        alu_done = 1;
        tick();
        button_clr = 0;
        alu_done = 0;
        tick();
        checks++;
        if ({state_o, disp_bcd, disp_neg} !== {3'd0, 16'h0, 1'b0}) begin
            fails++; $display("FAIL clr_done: got %0d/%h/%b required 0/0000/0", state_o, disp_bcd, disp_neg);
        end
    endtask

    task automatic test_reset_hold;
        reset = 1;
        slider_3 = 1;
        button_ent = 1;
        tick(2);
        reset = 0;
        tick(2);
        checks++;
        if ({state_o, operand_a} !== {3'd0, 16'h0}) begin
            fails++; $display("FAIL hold_release: got %0d/%h required 0/0000", state_o, operand_a);
        end
        slider_3 = 0;
        button_ent = 0;
        tick();
        checks++;
        if ({state_o, operand_a} !== {3'd0, 16'h0}) begin
            fails++; $display("FAIL hold_fall: got %0d/%h required 0/0000", state_o, operand_a);
        end
    endtask

    task automatic test_reset_wait;
        do_reset();
        press(1);
        exp_q.push_back({16'h0, 16'h0, 1'b0});
        press(1);
        reset = 1;
        tick();
        reset = 0;
        alu(16'h0003, 1, 0);
        checks++;
        if ({state_o, disp_bcd, disp_neg} !== {3'd0, 16'h0, 1'b0}) begin
            fails++; $display("FAIL late_done: got %0d/%h/%b required 0/0000/0", state_o, disp_bcd, disp_neg);
        end
    endtask

    task automatic test_timeout;
        do_reset();
        press(1);
        exp_q.push_back({16'h0, 16'h0, 1'b0});
        press(1);
`ifdef CALC_CTRL_TIMEOUT_EN
        tick(15);
        checks++;
        if (state_o !== 3'd3) begin fails++; $display("FAIL timeout_early: got %0d required 3", state_o); end
        tick();
        checks++;
        if ({state_o, disp_err} !== {3'd5, 1'b1}) begin
            fails++; $display("FAIL timeout_fire: got %0d/%b required 5/1", state_o, disp_err);
        end
`else
        tick(1000);
        checks++;
        if (state_o !== 3'd3) begin fails++; $display("FAIL no_timeout: got %0d required 3", state_o); end
`endif
        press(0);
        checks++;
        if (state_o !== 3'd0) begin fails++; $display("FAIL timeout_clr: got %0d required 0", state_o); end
    endtask

    initial begin
        checks = 0;
        fails = 0;
        last = '0;
        {reset, button_clr, button_ent, slider_1, slider_2, slider_3, slider_4, slider_arith} = '0;
        {alu_done, alu_neg, alu_ovf} = '0;
        alu_result = '0;
        test_reset();
        test_digits();
        test_sub_negative();
        test_chain_error();
        test_clr_priority();
        test_reset_hold();
        test_reset_wait();
        test_timeout();
        checks++;
        if (exp_q.size() != 0) begin
            fails++; $display("FAIL pending_starts: got %0d outstanding required 0", exp_q.size());
        end
        $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
        $finish;
    end
endmodule

// File: doc/calculator_ctrl.md
CALCULATOR_CTRL -- requirements
Module: calculator_ctrl

Interface
REQ-001 Parameter: TIMEOUT_CYCLES, 1024, ALU wait limit in clk cycles (>=2); used only with CALC_CTRL_TIMEOUT_EN.
REQ-002 clk  input  1  single system clock; all state updates on its rising edge.
REQ-003 reset  input  1  synchronous, active-high reset.
REQ-004 button_clr  input  1  debounced/synchronized clear-button level.
REQ-005 button_ent  input  1  debounced/synchronized enter-button level.
REQ-006 slider_1/slider_2/slider_3/slider_4  input  1 each  debounced/synchronized digit sliders (ones/tens/hundreds/thousands).
REQ-007 slider_arith  input  1  operation select: 0 = add, 1 = subtract.
REQ-008 alu_done  input  1  one-cycle ALU completion pulse.
REQ-009 alu_result  input  16  ALU result magnitude, 4-digit BCD; valid with alu_done.
REQ-010 alu_neg / alu_ovf  input  1 each  result negative / result overflow; valid with alu_done.
REQ-011 operand_a / operand_b  output  16  operands, 4-digit BCD, [3:0] = ones.
REQ-012 op_sub  output  1  latched operation to ALU.
REQ-013 alu_start  output  1  one-cycle ALU start pulse.
REQ-014 disp_bcd  output  16  value to display, 4-digit BCD.
REQ-015 disp_neg / disp_err  output  1 each  display minus sign / error indicator.
REQ-016 state_o  output  3  current state code.

Function
REQ-017 Edge detection: one previous-value register per button/slider; rising edge = current & ~previous; falling edges ignored.
REQ-018 States/codes: ENTER_A=0, ENTER_B=1, START=2, WAIT=3, RESULT=4, ERROR=5; codes 6-7 unreachable, SHALL go to ENTER_A.
REQ-019 In ENTER_A/ENTER_B, slider_k rising edge increments digit k-1 of the operand being entered (A resp. B) modulo 10 (9 -> 0, no carry); simultaneous edges each apply; slider edges ignored in all other states.
REQ-020 ENTER_A + ent edge: operand_b <= 0, go ENTER_B.
REQ-021 ENTER_B + ent edge: op_sub <= slider_arith, go START.
REQ-022 START: alu_start = 1 for exactly this one cycle, next state WAIT; alu_start = 0 in all other states.
REQ-023 WAIT + alu_done: latch alu_result/alu_neg; alu_ovf=1 -> ERROR, else RESULT; alu_done outside WAIT ignored.
REQ-024 RESULT + ent edge: alu_neg=0 -> operand_a <= latched result, operand_b <= 0, go ENTER_B; alu_neg=1 -> operand_a <= 0, go ENTER_A.
REQ-025 ERROR: ent and sliders ignored; only clr exits.
REQ-026 clr edge in any state: operands, op_sub, latched result/sign cleared, go ENTER_A next cycle; no alu_start issued; clr has priority over ent and alu_done in the same cycle.
REQ-027 operand_a, operand_b, op_sub SHALL remain stable from START entry until WAIT exits.
REQ-028 Display: ENTER_A -> operand_a; ENTER_B/START/WAIT -> operand_b; RESULT -> latched result with disp_neg = latched sign; ERROR -> 0 with disp_err=1; disp_neg=0 outside RESULT, disp_err=0 outside ERROR.
REQ-029 All outputs registered or decoded from registered state only; no combinational input-to-output path.

Reset
REQ-030 While reset=1: state ENTER_A, operand_a/operand_b/op_sub/latched result/sign = 0, alu_start=0, disp_*=0, timeout counter = 0.
REQ-031 While reset=1, previous-value registers load current input levels, so inputs held high through reset produce no edge after release.
REQ-032 Reset mid-operation (e.g. in WAIT) abandons the ALU transaction; a late alu_done is ignored.

Configuration
REQ-033 Macro CALC_CTRL_TIMEOUT_EN defined: counter runs in WAIT, cleared on WAIT entry; if TIMEOUT_CYCLES cycles elapse in WAIT without alu_done, go ERROR.
REQ-034 Macro CALC_CTRL_TIMEOUT_EN undefined: no counter; WAIT waits indefinitely for alu_done or clr.

Verification
REQ-035 Slider_1 x3, slider_2 x12 edges in ENTER_A -> operand_a = 16'h0023 (tens wrapped 9->0), disp_bcd = 16'h0023.
REQ-036 A=0012, ent, B=0005, slider_arith=1, ent -> one-cycle alu_start with operand_a=0012, operand_b=0005, op_sub=1; alu_done, result 0007, neg=1 -> RESULT, disp_bcd=0007, disp_neg=1; ent -> ENTER_A, operand_a=0.
REQ-037 RESULT with result 0042 non-negative, ent -> ENTER_B, operand_a=0042, operand_b=0; alu_done with alu_ovf=1 in a later WAIT -> ERROR, disp_err=1, disp_bcd=0.
REQ-038 clr and ent rising same cycle in ENTER_B -> ENTER_A, operands 0, no alu_start.
REQ-039 Hold slider_3 and button_ent high through reset, release -> no digit change, state ENTER_A.
REQ-040 With CALC_CTRL_TIMEOUT_EN, TIMEOUT_CYCLES=16, no alu_done -> ERROR after 16 WAIT cycles; without macro -> still WAIT after 1000 cycles.
